// File: rtl/store_write_buffer_pkg.sv
// Shared types for the store write buffer: FSM state encoding.
// Optional store-to-load forwarding is enabled by defining SWB_FORWARD_EN.
package store_write_buffer_pkg;

    typedef enum logic [1:0] {
        SWB_IDLE     = 2'd0,
        SWB_ST_DRAIN = 2'd1,
        SWB_LD_ISSUE = 2'd2
    } swb_state_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// CPU-side and memory_system-side signals of the store write buffer.
// slave = buffer view, master = environment (CPU + memory_system) view.
interface store_write_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] add_in;
    logic [DW-1:0] data_in;
    logic          stall;
    logic [DW-1:0] data_out;
    logic          ms_read;
    logic          ms_write;
    logic [AW-1:0] ms_add;
    logic [DW-1:0] ms_data;
    logic          ms_stall;
    logic [DW-1:0] ms_data_out;

    modport slave (
        input  mem_read, mem_write, add_in, data_in, ms_stall, ms_data_out,
        output stall, data_out, ms_read, ms_write, ms_add, ms_data
    );

    modport master (
        output mem_read, mem_write, add_in, data_in, ms_stall, ms_data_out,
        input  stall, data_out, ms_read, ms_write, ms_add, ms_data
    );
endinterface

// File: rtl/store_write_buffer_fifo.sv
// swb_fifo: store-entry storage, pointers and count.
// With SWB_FORWARD_EN it also returns the youngest entry matching a word address.
module swb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int EW    = 30,
    parameter  int DW    = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [EW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [EW-1:0] o_head_addr,
    output logic [DW-1:0] o_head_data,
    output logic [CW-1:0] o_count,
    output logic          o_full
`ifdef SWB_FORWARD_EN
    ,
    input  logic [EW-1:0] i_lookup_addr,
    output logic          o_hit,
    output logic [DW-1:0] o_hit_data
`endif
);
    logic [EW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PW'(1);
            if (i_pop)  r_head <= r_head + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_tail] <= i_addr;
            r_data[r_tail] <= i_data;
        end
    end

    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_count     = r_count;
    assign o_full      = (r_count == CW'(DEPTH));

`ifdef SWB_FORWARD_EN
    // Walk from tail-1 toward the head; the first valid match is the youngest.
    always_comb begin
        logic [PW-1:0] w_idx;
        o_hit      = 1'b0;
        o_hit_data = '0;
        w_idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_tail - PW'(i + 1);
            if (!o_hit && (CW'(i) < r_count) && (r_addr[w_idx] == i_lookup_addr)) begin
                o_hit      = 1'b1;
                o_hit_data = r_data[w_idx];
            end
        end
    end
`endif
endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer between the CPU MEM stage and memory_system.
// Define SWB_FORWARD_EN to build store-to-load forwarding.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    store_write_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW - 2;

    swb_state_t    r_state;
    swb_state_t    w_next;
    logic          r_ms_read;
    logic          r_ms_write;
    logic [AW-1:0] r_ms_add;
    logic [DW-1:0] r_ms_data;
    logic [DW-1:0] r_data_out;

    logic          w_ms_read_d;
    logic          w_ms_write_d;
    logic [AW-1:0] w_ms_add_d;
    logic [DW-1:0] w_ms_data_d;

    logic          w_load;
    logic          w_store;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_ld_go;
    logic          w_ld_done;
    logic          w_fwd_hit;
    logic [DW-1:0] w_fwd_data;
    logic [EW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic [CW-1:0] w_count;

    // A simultaneous load and store request is handled as a load.
    assign w_load    = bus.mem_read;
    assign w_store   = bus.mem_write & ~bus.mem_read;
    assign w_push    = w_store & ~w_full;
    assign w_pop     = (r_state == SWB_ST_DRAIN) & ~bus.ms_stall;
    assign w_ld_done = (r_state == SWB_LD_ISSUE) & ~bus.ms_stall;

`ifdef SWB_FORWARD_EN
    logic          w_hit;
    logic [DW-1:0] w_hit_data;

    swb_fifo #(.DEPTH(DEPTH), .EW(EW), .DW(DW)) u_fifo (
        .clk           (clk),
        .rst           (reset),
        .i_push        (w_push),
        .i_addr        (bus.add_in[AW-1:2]),
        .i_data        (bus.data_in),
        .i_pop         (w_pop),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_count       (w_count),
        .o_full        (w_full),
        .i_lookup_addr (bus.add_in[AW-1:2]),
        .o_hit         (w_hit),
        .o_hit_data    (w_hit_data)
    );

    assign w_fwd_hit  = w_load & w_hit;
    assign w_fwd_data = w_hit_data;
    assign w_ld_go    = w_load & ~w_hit;
`else
    swb_fifo #(.DEPTH(DEPTH), .EW(EW), .DW(DW)) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_addr      (bus.add_in[AW-1:2]),
        .i_data      (bus.data_in),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_count     (w_count),
        .o_full      (w_full)
    );

    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = '0;
    assign w_ld_go    = w_load & (w_count == '0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= SWB_IDLE;
            r_ms_read  <= 1'b0;
            r_ms_write <= 1'b0;
            r_ms_add   <= '0;
            r_ms_data  <= '0;
            r_data_out <= '0;
        end else begin
            r_state    <= w_next;
            r_ms_read  <= w_ms_read_d;
            r_ms_write <= w_ms_write_d;
            r_ms_add   <= w_ms_add_d;
            r_ms_data  <= w_ms_data_d;
            if (w_ld_done) r_data_out <= bus.ms_data_out;
        end
    end

    // Loads are evaluated only in IDLE, so a pending load waits out the store in flight.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            SWB_IDLE: begin
                if (w_ld_go)               w_next = SWB_LD_ISSUE;
                else if (w_count != '0)    w_next = SWB_ST_DRAIN;
            end
            SWB_ST_DRAIN: if (!bus.ms_stall) w_next = SWB_IDLE;
            SWB_LD_ISSUE: if (!bus.ms_stall) w_next = SWB_IDLE;
            default:      w_next = SWB_IDLE;
        endcase
    end

    always_comb begin
        w_ms_read_d  = (w_next == SWB_LD_ISSUE);
        w_ms_write_d = (w_next == SWB_ST_DRAIN);
        w_ms_add_d   = r_ms_add;
        w_ms_data_d  = r_ms_data;
        if (r_state == SWB_IDLE && w_next == SWB_ST_DRAIN) begin
            w_ms_add_d  = {w_head_addr, 2'b00};
            w_ms_data_d = w_head_data;
        end else if (r_state == SWB_IDLE && w_next == SWB_LD_ISSUE) begin
            w_ms_add_d  = bus.add_in;
        end
    end

    assign bus.stall    = w_load ? ~(w_fwd_hit | w_ld_done) : (w_store & w_full);
    assign bus.data_out = w_ld_done ? bus.ms_data_out :
                          w_fwd_hit ? w_fwd_data      : r_data_out;
    assign bus.ms_read  = r_ms_read;
    assign bus.ms_write = r_ms_write;
    assign bus.ms_add   = r_ms_add;
    assign bus.ms_data  = r_ms_data;

    a_no_load_and_store: assert property (@(posedge clk) disable iff (reset)
        !(bus.mem_read && bus.mem_write));
endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: queue-based model of posted stores checked every cycle,
// plus directed scenarios with literal expectations.
module tb_store_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    store_write_buffer_if #(.AW(AW), .DW(DW)) bus();

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    ent_t        q[$];
    logic        force_stall = 1'b0;
    int          mem_wait = 0;
    logic [31:0] log_a [64];
    logic [31:0] log_d [64];
    int          log_n = 0;
    int          n_reads = 0;

    function automatic logic [31:0] mem_rdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory_system responder: each request is stalled mem_wait cycles, then completes.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.ms_stall    = 1'b0;
        bus.ms_data_out = '0;
        forever begin
            @(posedge clk);
            #2;
            if (force_stall) begin
                bus.ms_stall = 1'b1;
            end else if (bus.ms_write || bus.ms_read) begin
                bus.ms_stall = (wcnt < mem_wait);
                if (bus.ms_stall) wcnt++;
                else wcnt = 0;
            end else begin
                bus.ms_stall = 1'b0;
                wcnt = 0;
            end
            bus.ms_data_out = bus.ms_read ? mem_rdata(bus.ms_add) : 32'hDEAD_BEEF;
        end
    end

    // Model compare: every cycle at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_ms_write", bus.ms_write, 0);
                chk("rst_ms_read", bus.ms_read, 0);
                chk("rst_data_out", bus.data_out, 0);
                q.delete();
            end else begin
                if (bus.mem_read) begin
                    logic        hit;
                    logic [31:0] hd;
                    logic        exp_stall;
                    hit = 1'b0;
                    hd  = '0;
`ifdef SWB_FORWARD_EN
                    for (int i = q.size() - 1; i >= 0; i--) begin
                        if (!hit && q[i].a[31:2] == bus.add_in[31:2]) begin
                            hit = 1'b1;
                            hd  = q[i].d;
                        end
                    end
`endif
                    exp_stall = !(hit || (bus.ms_read && !bus.ms_stall));
                    chk("load_stall", bus.stall, exp_stall);
                    if (!bus.stall)
                        chk("load_data_out", bus.data_out, hit ? hd : mem_rdata(bus.add_in));
                end else if (bus.mem_write) begin
                    chk("store_stall_iff_full", bus.stall, (q.size() == DEPTH));
                end else begin
                    chk("idle_stall", bus.stall, 0);
                end

                chk("ms_rw_exclusive", bus.ms_read & bus.ms_write, 0);
                if (bus.ms_write) begin
                    chk("ms_write_has_entry", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        chk("ms_add_head", bus.ms_add, q[0].a);
                        chk("ms_data_head", bus.ms_data, q[0].d);
                        if (!bus.ms_stall) begin
                            log_a[log_n] = bus.ms_add;
                            log_d[log_n] = bus.ms_data;
                            log_n++;
                            void'(q.pop_front());
                        end
                    end
                end
                if (bus.ms_read) begin
`ifndef SWB_FORWARD_EN
                    chk("ms_read_fifo_empty", q.size(), 0);
`endif
                    chk("ms_read_has_load", bus.mem_read, 1);
                    chk("ms_read_add", bus.ms_add, bus.add_in);
                    if (!bus.ms_stall) n_reads++;
                end

                if (bus.mem_write && !bus.mem_read && !bus.stall)
                    q.push_back('{a: {bus.add_in[31:2], 2'b00}, d: bus.data_in});
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
        logic ok;
        ok = 1'b0;
        stalls = 0;
        bus.mem_write = 1'b1;
        bus.add_in    = a;
        bus.data_in   = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus.stall) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        chk("store_accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int stalls);
        logic ok;
        ok = 1'b0;
        stalls = 0;
        d = '0;
        bus.mem_read = 1'b1;
        bus.add_in   = a;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus.stall) begin
                ok = 1'b1;
                d  = bus.data_out;
                break;
            end
            stalls++;
        end
        chk("load_done_timeout", ok, 1);
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
    endtask

    task automatic wait_drain();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !bus.ms_write && !bus.ms_read) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", ok, 1);
    endtask

    initial begin
        int          s;
        int          s5;
        int          ls;
        int          nw;
        logic [31:0] d;
        logic        ok;

        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.add_in    = '0;
        bus.data_in   = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ms_write", bus.ms_write, 0);
        chk("reset_ms_read", bus.ms_read, 0);
        chk("reset_stall", bus.stall, 0);
        chk("reset_data_out", bus.data_out, 0);
        reset = 1'b0;

        // Zero-wait back-to-back stores, memory stalls each write twice
        mem_wait = 2;
        log_n = 0;
        do_store(32'h100, 32'h11, s);
        chk("zw_A_no_stall", s, 0);
        do_store(32'h104, 32'h22, s);
        chk("zw_B_no_stall", s, 0);
        wait_drain();
        chk("zw_log_n", log_n, 2);
        chk("zw_first_add", log_a[0], 32'h100);
        chk("zw_first_data", log_d[0], 32'h11);
        chk("zw_second_add", log_a[1], 32'h104);
        chk("zw_second_data", log_d[1], 32'h22);

        // Fill to DEPTH with memory blocked, 5th store must wait for the head to pop
        mem_wait = 0;
        force_stall = 1'b1;
        log_n = 0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h600 + 32'(4 * i), 32'h61 + 32'(i), s);
            chk("fill_zero_wait", s, 0);
        end
        fork
            do_store(32'h610, 32'h65, s5);
            begin
                repeat (6) @(posedge clk);
                #1;
                force_stall = 1'b0;
            end
        join
        chk("fill_5th_stalled", s5 >= 6, 1);
        wait_drain();
        chk("fill_log_n", log_n, 5);
        for (int i = 0; i < 5; i++) begin
            chk("fill_order_add", log_a[i], 32'h600 + 32'(4 * i));
            chk("fill_order_data", log_d[i], 32'h61 + 32'(i));
        end
        chk("fill_last_add", log_a[4], 32'h610);

        // Load behind a queued store goes to memory after the drain
        mem_wait = 1;
        log_n = 0;
        n_reads = 0;
        do_store(32'h200, 32'hAB, s);
        do_load(32'h300, d, ls);
        chk("ld_data", d, 32'h5A5A_0300);
        chk("ld_was_stalled", ls > 0, 1);
        chk("ld_store_drained_first", log_n, 1);
        chk("ld_store_add", log_a[0], 32'h200);
        chk("ld_read_count", n_reads, 1);
        do_load(32'h304, d, ls);
        chk("ld_empty_data", d, 32'h5A5A_0304);

`ifdef SWB_FORWARD_EN
        // Youngest matching store is forwarded without a memory read
        force_stall = 1'b1;
        n_reads = 0;
        do_store(32'h40, 32'h1, s);
        do_store(32'h40, 32'h2, s);
        do_load(32'h42, d, ls);
        chk("fwd_data", d, 32'h2);
        chk("fwd_no_stall", ls, 0);
        chk("fwd_no_ms_read", n_reads, 0);
        force_stall = 1'b0;
        wait_drain();
`endif

        // Wrap-around: 12 stores through a 4-entry buffer
        mem_wait = 1;
        log_n = 0;
        for (int i = 0; i < 12; i++)
            do_store(32'h800 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), s);
        wait_drain();
        chk("wrap_log_n", log_n, 12);
        for (int i = 0; i < 12; i++) begin
            chk("wrap_order_add", log_a[i], 32'h800 + 32'(4 * i));
            chk("wrap_order_data", log_d[i], 32'hC0DE_0000 + 32'(i));
        end
        chk("wrap_last_add", log_a[11], 32'h82C);
        chk("wrap_last_data", log_d[11], 32'hC0DE_000B);

        // Reset in the middle of a stalled drain drops everything
        force_stall = 1'b1;
        for (int i = 0; i < 3; i++)
            do_store(32'h500 + 32'(4 * i), 32'h50 + 32'(i), s);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (bus.ms_write) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rd_drain_started", ok, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rd_ms_write_drop", bus.ms_write, 0);
        chk("rd_ms_read_low", bus.ms_read, 0);
        chk("rd_data_out_zero", bus.data_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        force_stall = 1'b0;
        nw = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ms_write) nw++;
        end
        chk("rd_no_further_write", nw, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
